// File: rtl/keypad_scanner.sv
// Column-scanning matrix keypad decoder with debounced press/release strobes.
// Define KEYPAD_REPEAT_EN to add auto-repeat of key_valid while a key is held.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int CODE_W       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_release
);

    localparam int CI_W  = $clog2(COLS);
    localparam int RI_W  = $clog2(ROWS);
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

    generate
        if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || (1 << CODE_W) < ROWS * COLS ||
            SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("keypad_scanner: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

    state_t            state_q, state_d;
    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CI_W-1:0]   col_idx_q, col_idx_d, col_next;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;
    logic              key_release_q, key_release_d;

    logic              tick;
    logic              any_low;
    logic [RI_W-1:0]   row_idx;
    logic [CODE_W-1:0] code_cur;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
    logic             rep_run_q, rep_run_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    assign tick     = (presc_q == PS_W'(SCAN_DIV - 1));
    assign presc_d  = tick ? '0 : presc_q + 1'b1;
    assign col_next = (col_idx_q == CI_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;

    // Lowest-index pressed row wins when several rows are low.
    always_comb begin
        any_low = 1'b0;
        row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_sync_q[i]) begin
                any_low = 1'b1;
                row_idx = RI_W'(i);
            end
        end
    end

    assign code_cur = CODE_W'(col_idx_q) * CODE_W'(ROWS) + CODE_W'(row_idx);

`ifdef KEYPAD_REPEAT_EN
    assign rep_limit = rep_run_q ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        rcnt_d        = rcnt_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_held_d    = key_held_q;
        key_release_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d     = rep_cnt_q;
        rep_run_d     = rep_run_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (any_low) begin
                        cand_d  = code_cur;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_next;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (any_low && code_cur == cand_q) begin
                        if (cnt_q >= DEB_LAST) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            rcnt_d      = '0;
                            state_d     = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = '0;
                            rep_run_d   = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        // Bounce or a different key: resume scanning from the same column.
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_HELD: begin
                if (tick) begin
                    if (!any_low) begin
                        if (rcnt_q >= DEB_LAST) begin
                            key_release_d = 1'b1;
                            key_held_d    = 1'b0;
                            rcnt_d        = '0;
                            col_idx_d     = col_next;
                            state_d       = ST_SCAN;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d     = '0;
                            rep_run_d     = 1'b0;
`endif
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end else begin
                        rcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt_q >= rep_limit) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_run_d   = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SCAN;
            presc_q       <= '0;
            col_idx_q     <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            rcnt_q        <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            col_idx_q     <= col_idx_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            rcnt_q        <= rcnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
            key_release_q <= key_release_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q <= '0;
            rep_run_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
        end
    end
`endif

    // One-cold column drive decoded from the column index.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            assign col[gi] = (col_idx_q != CI_W'(gi));
        end
    endgenerate

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign key_release = key_release_q;

endmodule
